// File: rtl/ac97_pkg.sv
// Shared AC97 widths, codec register addresses and command-arbiter state encoding.
package ac97_pkg;

  localparam int AC97_SLOT_W = 20;
  localparam int AC97_ADDR_W = 7;
  localparam int AC97_DATA_W = 16;

  localparam logic [AC97_ADDR_W-1:0] AC97_REG_RESET      = 7'h00;
  localparam logic [AC97_ADDR_W-1:0] AC97_REG_MASTER_VOL = 7'h02;
  localparam logic [AC97_ADDR_W-1:0] AC97_REG_PCM_VOL    = 7'h18;
  localparam logic [AC97_ADDR_W-1:0] AC97_REG_POWERDOWN  = 7'h26;
  localparam logic [AC97_ADDR_W-1:0] AC97_REG_VID0       = 7'h7C;
  localparam logic [AC97_ADDR_W-1:0] AC97_REG_VID1       = 7'h7E;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    IDLE     = 2'd1,
    ISSUE    = 2'd2,
    WAIT_RSP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ac97_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr wins.
module ac97_rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int   w_idx;
  logic w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (en && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gnt_idx    = IW'(w_idx);
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ac97_cmd_arbiter.sv
// Frame-aligned AC97 command slot arbiter with read-response matching and timeout.
// Optional codec-reset write after reset is enabled with `define AC97_CMD_RESET_EN.
module ac97_cmd_arbiter
  import ac97_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_FRAMES = 8
) (
  input  logic                   ac97_bitclk,
  input  logic                   reset_b,
  input  logic                   ac97_strobe,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_rd,
  input  logic [7*NREQ-1:0]      req_addr,
  input  logic [16*NREQ-1:0]     req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [19:0]            ac97_out_slot1,
  output logic                   ac97_out_slot1_valid,
  output logic [19:0]            ac97_out_slot2,
  output logic                   ac97_out_slot2_valid,
  input  logic [19:0]            ac97_in_slot1,
  input  logic                   ac97_in_slot1_valid,
  input  logic [19:0]            ac97_in_slot2,
  input  logic                   ac97_in_slot2_valid,
  output logic                   rsp_valid,
  output logic                   rsp_timeout,
  output logic [2:0]             rsp_id,
  output logic [15:0]            rsp_data,
  output logic                   busy,
  output logic [1:0]             o_dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e              r_state, w_next;
  logic [IW-1:0]           r_ptr;
  logic [7:0]              r_cnt;
  logic                    r_rd;
  logic [AC97_ADDR_W-1:0]  r_addr;
  logic [2:0]              r_gid;
  logic [19:0]             r_slot1, r_slot2;
  logic                    r_slot1_v, r_slot2_v;
  logic [AC97_DATA_W-1:0]  r_rsp_data;

  logic [NREQ-1:0]         w_gnt;
  logic [IW-1:0]           w_gidx;
  logic                    w_granted, w_grant_en, w_boot_exit;
  logic                    w_sel_rd;
  logic [AC97_ADDR_W-1:0]  w_sel_addr;
  logic [AC97_DATA_W-1:0]  w_sel_data;
  logic                    w_match, w_in_wait, w_rsp_valid, w_rsp_timeout;
  logic                    w_unused;

  // Handshake: req_ready[g] is a single-cycle grant in a strobe cycle; the request
  // fields of g are sampled in that same cycle and the requester must drop or change them.
`ifdef AC97_CMD_RESET_EN
  assign w_boot_exit = (r_state == BOOT) && (r_cnt == 8'd3);
`else
  assign w_boot_exit = 1'b0;
`endif

  assign w_grant_en = ac97_strobe &&
                      ((r_state == IDLE) || ((r_state == ISSUE) && !r_rd) || w_boot_exit);

  ac97_rr_arbiter #(.N(NREQ)) u_rr (
    .req     (req_valid),
    .ptr     (r_ptr),
    .en      (w_grant_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gidx)
  );

  assign w_granted  = |w_gnt;
  assign w_sel_rd   = req_rd[w_gidx];
  assign w_sel_addr = req_addr[int'(w_gidx)*AC97_ADDR_W +: AC97_ADDR_W];
  assign w_sel_data = req_data[int'(w_gidx)*AC97_DATA_W +: AC97_DATA_W];

  assign w_match       = ac97_in_slot1_valid && ac97_in_slot2_valid &&
                         (ac97_in_slot1[18:12] == r_addr);
  assign w_in_wait     = ac97_strobe && (r_state == WAIT_RSP);
  assign w_rsp_valid   = w_in_wait && w_match;
  assign w_rsp_timeout = w_in_wait && !w_match && (r_cnt == 8'(TIMEOUT_FRAMES - 1));
  assign w_unused      = ^{ac97_in_slot1[19], ac97_in_slot1[11:0], ac97_in_slot2[3:0]};

  always_ff @(posedge ac97_bitclk or negedge reset_b) begin
    if (!reset_b) begin
`ifdef AC97_CMD_RESET_EN
      r_state <= BOOT;
`else
      r_state <= IDLE;
`endif
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (ac97_strobe) begin
      case (r_state)
        BOOT:     if (w_boot_exit) w_next = w_granted ? ISSUE : IDLE;
        IDLE:     if (w_granted) w_next = ISSUE;
        ISSUE:    if (r_rd) w_next = WAIT_RSP;
                  else if (!w_granted) w_next = IDLE;
        WAIT_RSP: if (w_rsp_valid || w_rsp_timeout) w_next = IDLE;
      endcase
    end
  end

  // Slot registers only move on strobe so ACLink sees one stable command per frame.
  always_ff @(posedge ac97_bitclk or negedge reset_b) begin
    if (!reset_b) begin
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_rd       <= 1'b0;
      r_addr     <= '0;
      r_gid      <= '0;
      r_slot1    <= '0;
      r_slot2    <= '0;
      r_slot1_v  <= 1'b0;
      r_slot2_v  <= 1'b0;
      r_rsp_data <= '0;
    end else if (ac97_strobe) begin
      if (w_granted) begin
        r_ptr     <= IW'((int'(w_gidx) + 1) % NREQ);
        r_rd      <= w_sel_rd;
        r_addr    <= w_sel_addr;
        r_gid     <= 3'(w_gidx);
        r_slot1   <= {w_sel_rd, w_sel_addr, 12'h000};
        r_slot2   <= w_sel_rd ? 20'h00000 : {w_sel_data, 4'h0};
        r_slot1_v <= 1'b1;
        r_slot2_v <= 1'b1;
      end else begin
        case (r_state)
          ISSUE: begin
            r_slot1_v <= 1'b0;
            r_slot2_v <= 1'b0;
            r_cnt     <= '0;
          end
          WAIT_RSP: begin
            if (w_rsp_valid) r_rsp_data <= ac97_in_slot2[19:4];
            else             r_cnt      <= r_cnt + 8'd1;
          end
`ifdef AC97_CMD_RESET_EN
          BOOT: begin
            if (r_cnt == 8'd0) begin
              r_slot1   <= {1'b0, AC97_REG_RESET, 12'h000};
              r_slot2   <= 20'h00000;
              r_slot1_v <= 1'b1;
              r_slot2_v <= 1'b1;
            end else if (r_cnt == 8'd1) begin
              r_slot1_v <= 1'b0;
              r_slot2_v <= 1'b0;
            end
            if (r_cnt != 8'd3) r_cnt <= r_cnt + 8'd1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    req_ready            = w_gnt;
    ac97_out_slot1       = r_slot1;
    ac97_out_slot1_valid = r_slot1_v;
    ac97_out_slot2       = r_slot2;
    ac97_out_slot2_valid = r_slot2_v;
    rsp_valid            = w_rsp_valid;
    rsp_timeout          = w_rsp_timeout;
    rsp_id               = (w_rsp_valid || w_rsp_timeout) ? r_gid : 3'd0;
    rsp_data             = w_rsp_valid ? ac97_in_slot2[19:4] : r_rsp_data;
    busy                 = (r_state != IDLE);
    o_dbg_state          = r_state;
  end

endmodule

// File: tb/tb_ac97_cmd_arbiter.sv
// Frame-level scoreboard bench for ac97_cmd_arbiter (directed cases then random frames).
module tb_ac97_cmd_arbiter;
  import ac97_pkg::*;

  localparam int NREQ  = 2;
  localparam int TO    = 8;
  localparam int FRAME = 6;
  localparam int EV_W  = NREQ + 1 + 1 + 3 + 16;
  localparam int SL_W  = 20 + 1 + 20 + 1 + 1 + 16;
  localparam int PH_IDLE = 0, PH_WR = 1, PH_RD = 2, PH_WAIT = 3, PH_BOOT = 4;

  logic                 clk = 1'b0;
  logic                 reset_b = 1'b0;
  logic                 ac97_strobe = 1'b0;
  logic [NREQ-1:0]      req_valid = '0, req_rd = '0;
  logic [7*NREQ-1:0]    req_addr = '0;
  logic [16*NREQ-1:0]   req_data = '0;
  logic [19:0]          in_slot1 = '0, in_slot2 = '0;
  logic                 in_slot1_valid = 1'b0, in_slot2_valid = 1'b0;
  logic [NREQ-1:0]      req_ready;
  logic [19:0]          out_slot1, out_slot2;
  logic                 out_slot1_valid, out_slot2_valid;
  logic                 rsp_valid, rsp_timeout, busy;
  logic [2:0]           rsp_id;
  logic [15:0]          rsp_data;
  logic [1:0]           dbg_state;

  ac97_cmd_arbiter #(.NREQ(NREQ), .TIMEOUT_FRAMES(TO)) dut (
    .ac97_bitclk(clk), .reset_b(reset_b), .ac97_strobe(ac97_strobe),
    .req_valid(req_valid), .req_rd(req_rd), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .ac97_out_slot1(out_slot1), .ac97_out_slot1_valid(out_slot1_valid),
    .ac97_out_slot2(out_slot2), .ac97_out_slot2_valid(out_slot2_valid),
    .ac97_in_slot1(in_slot1), .ac97_in_slot1_valid(in_slot1_valid),
    .ac97_in_slot2(in_slot2), .ac97_in_slot2_valid(in_slot2_valid),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one step per frame strobe) ----------------
  logic [EV_W-1:0] exp_q[$];
  logic [SL_W-1:0] exp_slot_q[$];

  int         m_phase, m_ptr, m_wait, m_boot, m_gid;
  logic [6:0] m_addr;
  logic [15:0] m_rsp_data;

  task automatic model_reset();
`ifdef AC97_CMD_RESET_EN
    m_phase = PH_BOOT;
`else
    m_phase = PH_IDLE;
`endif
    m_ptr = 0; m_wait = 0; m_boot = 0; m_gid = 0;
    m_addr = '0; m_rsp_data = '0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] rv, input logic [NREQ-1:0] rd,
                            input logic [7*NREQ-1:0] ad, input logic [16*NREQ-1:0] da,
                            input logic [19:0] i1, input logic i1v,
                            input logic [19:0] i2, input logic i2v);
    logic [NREQ-1:0] e_ready = '0;
    logic e_rv = 1'b0, e_to = 1'b0, v1 = 1'b0, v2 = 1'b0, e_busy;
    logic [2:0] e_id = '0;
    logic [15:0] e_data = '0;
    logic [19:0] s1 = '0, s2 = '0;
    bit can_grant = 0;
    case (m_phase)
      PH_BOOT: begin
        m_boot++;
        if (m_boot == 1) begin v1 = 1'b1; v2 = 1'b1; end
        else if (m_boot == 4) can_grant = 1;
      end
      PH_IDLE, PH_WR: can_grant = 1;
      PH_RD: begin m_phase = PH_WAIT; m_wait = 0; end
      PH_WAIT: begin
        if (i1v && i2v && (i1[18:12] == m_addr)) begin
          e_rv = 1'b1; e_id = 3'(m_gid); e_data = i2[19:4];
          m_rsp_data = i2[19:4]; m_phase = PH_IDLE;
        end else begin
          m_wait++;
          if (m_wait == TO) begin e_to = 1'b1; e_id = 3'(m_gid); m_phase = PH_IDLE; end
        end
      end
      default: ;
    endcase
    if (can_grant) begin
      m_phase = PH_IDLE;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (rv[idx] && e_ready == '0) begin
          e_ready[idx] = 1'b1;
          m_gid  = idx;
          m_ptr  = (idx + 1) % NREQ;
          m_addr = ad[7*idx +: 7];
          m_phase = rd[idx] ? PH_RD : PH_WR;
          s1 = {rd[idx], ad[7*idx +: 7], 12'h000};
          s2 = rd[idx] ? 20'h00000 : {da[16*idx +: 16], 4'h0};
          v1 = 1'b1; v2 = 1'b1;
        end
      end
    end
    e_busy = (m_phase != PH_IDLE);
    exp_q.push_back({e_ready, e_rv, e_to, e_id, e_data});
    exp_slot_q.push_back({s1, v1, s2, v2, e_busy, m_rsp_data});
  endtask

  // ---------------- monitor / scoreboard ----------------
  int              since = 100;
  logic [EV_W-1:0] ev;
  logic [SL_W-1:0] sl;
  logic [NREQ-1:0] x_ready;
  logic            x_rv, x_to, x_v1, x_v2, x_busy;
  logic [2:0]      x_id;
  logic [15:0]     x_data, x_hold;
  logic [19:0]     x_s1, x_s2;

  always @(negedge clk) begin
    if (!reset_b) begin
      since = 100;
    end else if (ac97_strobe) begin
      since = 0;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL ev_underflow: got strobe expected queued event");
      end else begin
        ev = exp_q.pop_front();
        {x_ready, x_rv, x_to, x_id, x_data} = ev;
        chk("req_ready", req_ready, x_ready);
        chk("rsp_valid", rsp_valid, x_rv);
        chk("rsp_timeout", rsp_timeout, x_to);
        if (x_rv || x_to) chk("rsp_id", rsp_id, x_id);
        if (x_rv) chk("rsp_data_pulse", rsp_data, x_data);
      end
    end else begin
      chk("quiet_pulses", {req_ready, rsp_valid, rsp_timeout}, '0);
      since++;
      if (since == 2) begin
        if (exp_slot_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL slot_underflow: got frame expected queued slots");
        end else begin
          sl = exp_slot_q.pop_front();
          {x_s1, x_v1, x_s2, x_v2, x_busy, x_hold} = sl;
          chk("slot1_valid", out_slot1_valid, x_v1);
          chk("slot2_valid", out_slot2_valid, x_v2);
          if (x_v1) chk("slot1", out_slot1, x_s1);
          if (x_v2) chk("slot2", out_slot2, x_s2);
          chk("busy", busy, x_busy);
          chk("rsp_data_held", rsp_data, x_hold);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic frame(input logic [NREQ-1:0] f_rv, input logic [NREQ-1:0] f_rd,
                       input logic [7*NREQ-1:0] f_addr, input logic [16*NREQ-1:0] f_data,
                       input logic [19:0] f_i1, input logic f_i1v,
                       input logic [19:0] f_i2, input logic f_i2v);
    @(posedge clk); #1;
    req_valid = f_rv; req_rd = f_rd; req_addr = f_addr; req_data = f_data;
    in_slot1 = f_i1; in_slot1_valid = f_i1v; in_slot2 = f_i2; in_slot2_valid = f_i2v;
    ac97_strobe = 1'b1;
    model_step(f_rv, f_rd, f_addr, f_data, f_i1, f_i1v, f_i2, f_i2v);
    @(posedge clk); #1;
    ac97_strobe = 1'b0;
    repeat (FRAME - 2) @(posedge clk);
    #1;
  endtask

  task automatic idle_frame();
    frame('0, '0, '0, '0, 20'h0, 1'b0, 20'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_b = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_slots", {out_slot1, out_slot1_valid, out_slot2, out_slot2_valid}, '0);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_id, rsp_data}, '0);
`ifdef AC97_CMD_RESET_EN
    chk("rst_busy", busy, 1'b1);
`else
    chk("rst_busy", busy, 1'b0);
`endif
    exp_q.delete();
    exp_slot_q.delete();
    model_reset();
    req_valid = '0; req_rd = '0; req_addr = '0; req_data = '0;
    in_slot1 = '0; in_slot2 = '0; in_slot1_valid = 1'b0; in_slot2_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_b = 1'b1;
  endtask

  task automatic boot_frames();
`ifdef AC97_CMD_RESET_EN
    for (int b = 0; b < 3; b++) begin
      frame(2'b01, 2'b00, {7'h00, AC97_REG_MASTER_VOL}, {16'h0, 16'hAAAA},
            20'h0, 1'b0, 20'h0, 1'b0);
      if (b == 0) chk("boot_slot1", {out_slot1, out_slot1_valid}, {20'h00000, 1'b1});
    end
`endif
  endtask

  function automatic logic [6:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return AC97_REG_MASTER_VOL;
      1: return AC97_REG_PCM_VOL;
      2: return AC97_REG_POWERDOWN;
      3: return AC97_REG_VID0;
      default: return AC97_REG_VID1;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [NREQ-1:0]    r_rv, r_rd;
    logic [7*NREQ-1:0]  r_ad;
    logic [16*NREQ-1:0] r_da;
    logic [19:0]        r_i1, r_i2;
    logic               r_i1v, r_i2v;

    model_reset();
    do_reset();
    boot_frames();

    // write from req0
    frame(2'b01, 2'b00, {7'h00, AC97_REG_MASTER_VOL}, 32'h0, 20'h0, 1'b0, 20'h0, 1'b0);
    chk("wr_slot1", out_slot1, 20'h02000);
    chk("wr_slot2", out_slot2, 20'h00000);
    chk("wr_valids", {out_slot1_valid, out_slot2_valid}, 2'b11);
    idle_frame();
    chk("wr_done_valids", {out_slot1_valid, out_slot2_valid}, 2'b00);

    // read from req1 with matching response
    frame(2'b10, 2'b10, {AC97_REG_POWERDOWN, 7'h00}, 32'h0, 20'h0, 1'b0, 20'h0, 1'b0);
    chk("rd_slot1", out_slot1, 20'hA6000);
    idle_frame();
    frame('0, '0, '0, '0, 20'h26000, 1'b1, 20'h000F0, 1'b1);
    chk("rd_data", rsp_data, 16'h000F);
    chk("rd_busy_after", busy, 1'b0);

    // both requesters writing for four frames
    repeat (4) frame(2'b11, 2'b00, {AC97_REG_PCM_VOL, AC97_REG_MASTER_VOL},
                     {16'h1234, 16'h5678}, 20'h0, 1'b0, 20'h0, 1'b0);
    idle_frame();

    // read that never matches -> timeout
    frame(2'b01, 2'b01, {7'h00, AC97_REG_VID0}, 32'h0, 20'h0, 1'b0, 20'h0, 1'b0);
    idle_frame();
    for (int i = 0; i < TO; i++) begin
      frame('0, '0, '0, '0, 20'h26000, 1'b1, 20'h12340, 1'b1);
      if (i == TO - 2) chk("to_busy_before", busy, 1'b1);
    end
    chk("to_busy_after", busy, 1'b0);

    // reset while waiting on a read
    frame(2'b10, 2'b10, {AC97_REG_VID1, 7'h00}, 32'h0, 20'h0, 1'b0, 20'h0, 1'b0);
    idle_frame();
    idle_frame();
    chk("pre_reset_busy", busy, 1'b1);
    do_reset();
    boot_frames();
    frame(2'b01, 2'b00, {7'h00, AC97_REG_PCM_VOL}, {16'h0, 16'hBEEF},
          20'h0, 1'b0, 20'h0, 1'b0);
    chk("post_reset_slot2", out_slot2, 20'hBEEF0);
    idle_frame();

    // randomized frames
    for (int f = 0; f < 250; f++) begin
      r_rv = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      r_rd = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int k = 0; k < NREQ; k++) begin
        r_ad[7*k +: 7]   = pick_addr();
        r_da[16*k +: 16] = 16'($urandom);
      end
      if (m_phase == PH_WAIT && $urandom_range(0, 2) == 0) begin
        r_i1 = {1'b0, m_addr, 12'h000}; r_i1v = 1'b1;
        r_i2 = {16'($urandom), 4'h0};   r_i2v = 1'b1;
      end else begin
        r_i1 = {1'b0, pick_addr(), 12'h000}; r_i1v = 1'($urandom_range(0, 1));
        r_i2 = 20'($urandom);                r_i2v = 1'($urandom_range(0, 1));
      end
      frame(r_rv, r_rd, r_ad, r_da, r_i1, r_i1v, r_i2, r_i2v);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("ev_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("slot_queue_drained", 64'(exp_slot_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ac97_cmd_arbiter.md
Name: ac97_cmd_arbiter

Overview:
- Sequences AC97 codec register accesses (slot 1 command address, slot 2 command data) on the AC-link and shares them among NREQ requesters, e.g. the init sequencer and a volume controller.
- Issues at most one command per frame, aligned to ac97_strobe.
- For reads, matches the codec status response (input slots 1/2) and returns the data, or reports a timeout.
- Sits between the requesters and ACLink's slot1/slot2 inputs.

Parameters:
NREQ, 2, number of requesters (1..8)
TIMEOUT_FRAMES, 8, frames to wait for a read response before abandoning it (2..255)

Ports:
ac97_bitclk  in  1  AC-link bit clock; only clock
reset_b  in  1  asynchronous active-low reset
ac97_strobe  in  1  frame-boundary pulse, one cycle per 256 bits
req_valid  in  NREQ  request pending, per requester
req_rd  in  NREQ  1=read, 0=write
req_addr  in  7*NREQ  register address, requester i at [7i+6:7i]
req_data  in  16*NREQ  write data, requester i at [16i+15:16i]
req_ready  out  NREQ  one-cycle grant pulse; request consumed
ac97_out_slot1  out  20  command address slot to ACLink
ac97_out_slot1_valid  out  1  slot 1 tag bit
ac97_out_slot2  out  20  command data slot to ACLink
ac97_out_slot2_valid  out  1  slot 2 tag bit
ac97_in_slot1  in  20  status address slot from previous frame
ac97_in_slot1_valid  in  1  input tag bit, slot 1
ac97_in_slot2  in  20  status data slot from previous frame
ac97_in_slot2_valid  in  1  input tag bit, slot 2
rsp_valid  out  1  one-cycle pulse, read data returned
rsp_timeout  out  1  one-cycle pulse, read abandoned
rsp_id  out  3  requester index for rsp_valid / rsp_timeout
rsp_data  out  16  read data, held until next response
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, ac97_bitclk. reset_b is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0.
- Update rule: every state change and every slot output update occurs only in a cycle where ac97_strobe=1. This keeps slot values stable for the whole frame.
- IDLE:
  - On strobe with any req_valid set, grant round-robin starting at the pointer.
  - Pulse req_ready[g] in that same cycle.
  - Latch rd, addr and data; pointer <= g+1 mod NREQ.
  - Drive slot1={rd,addr,12'h0}, slot1_valid=1, slot2_valid=1.
  - slot2={data,4'h0} for a write; 20'h0 for a read.
  - Go to ISSUE.
- ISSUE (command transmitted during this frame):
  - Write: at next strobe the write is complete. If another request is pending, grant it in the same cycle (back-to-back, one command per frame). Otherwise clear both valids and go to IDLE.
  - Read: at next strobe clear both valids, counter <= 0, go to WAIT_RSP.
- WAIT_RSP, evaluated on each strobe:
  - Match condition: in_slot1_valid & in_slot2_valid & in_slot1[18:12]==addr.
  - On match: rsp_data <= in_slot2[19:4], pulse rsp_valid with rsp_id=g, go to IDLE.
  - No match: counter++. If counter reaches TIMEOUT_FRAMES-1, pulse rsp_timeout, go to IDLE.
  - No new grants are made while in WAIT_RSP, so only one read is outstanding.
- Response pulse, timing: it fires in the same strobe cycle. A new grant may also occur in that cycle, but only from IDLE on the following strobe; the response and the new grant are never the same cycle.
- req_valid dropped before its grant: the request is ignored; no partial command is issued.
- Reset mid-frame: outputs drop to 0 immediately (asynchronous). Any in-flight command or read is lost and no response pulse is issued.
- Strobe while no request is pending: outputs unchanged in IDLE (valids stay 0).

Optional Feature:
AC97_CMD_RESET_EN
- Defined: after reset the block enters BOOT, not IDLE. On the first strobe it issues write addr 0x00 data 0x0000 (codec reset), keeps busy=1, and ignores requesters for that frame plus 2 further frames, then goes to IDLE. No req_ready pulses occur during this time.
- Undefined: BOOT state is absent; reset goes straight to IDLE.

Decomposition:
- Package ac97_pkg holds:
  - AC97_SLOT_W=20, AC97_ADDR_W=7, AC97_DATA_W=16
  - Register constants: AC97_REG_RESET=7'h00, AC97_REG_MASTER_VOL=7'h02, AC97_REG_PCM_VOL=7'h18, AC97_REG_POWERDOWN=7'h26, AC97_REG_VID0=7'h7C, AC97_REG_VID1=7'h7E
  - Enum of arbiter states: BOOT, IDLE, ISSUE, WAIT_RSP
- Sub-module: ac97_rr_arbiter. Parameter N; inputs req[N], ptr, en; outputs gnt one-hot and gnt_idx. Purely combinational, with the pointer register kept in the parent.

Test Plan:
- Write from req0 (addr 0x02, data 0x0000): req_ready[0] pulses at the first strobe; the next frame carries slot1=20'h02000, slot2=20'h00000 with both valids set; the frame after that carries no valids.
- Simultaneous req0 and req1 writes held for 4 frames: grants alternate 0,1,0,1, one per frame; the pointer advances each time.
- Read from req1 of addr 0x26: slot1=20'hA6000 is sent. Feed in_slot1=20'h26000 and in_slot2=20'h000F0 (both valid) at the next strobe: rsp_valid pulses with rsp_id=1 and rsp_data=0x000F.
- Read of 0x7C where responses carry addr 0x26 only: no match. rsp_timeout pulses at the 8th WAIT_RSP strobe; busy falls in that same cycle.
- reset_b asserted mid-WAIT_RSP: all outputs go to 0 at once with no response pulse; after release a fresh request is granted at the next strobe (or after the BOOT write when AC97_CMD_RESET_EN is defined).
- AC97_CMD_RESET_EN defined: the first command frame is addr 0x00 write. A requester holding req_valid from reset receives no grant during the BOOT frames; it is granted on the strobe at which BOOT returns to IDLE.
